// File: rtl/counter_run_ctrl_if.sv
// Command/status bundle between the button debouncers, the run controller and the FND display path.
interface counter_run_ctrl_if;
    logic        i_run_stop;
    logic        i_clear;
    logic        i_mode;
    logic [13:0] o_cnt_data;
    logic        o_run;
    logic        o_tick;

    modport master (
        output i_run_stop,
        output i_clear,
        output i_mode,
        input  o_cnt_data,
        input  o_run,
        input  o_tick
    );

    modport slave (
        input  i_run_stop,
        input  i_clear,
        input  i_mode,
        output o_cnt_data,
        output o_run,
        output o_tick
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// RUN/STOP/CLEAR sequencer for the 0..MAX_COUNT display counter.
// Owns the prescaler that paces the count tick and the 14-bit count register.
module counter_run_ctrl #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 10,
    parameter int unsigned MAX_COUNT = 9999
) (
    input  logic                clk,
    input  logic                rst,
    counter_run_ctrl_if.slave   bus
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = 14;

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q;
    logic               tick_c;

    // Next state, prescaler and count; the prescaler holds while stopped so a resume finishes the interval.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        cnt_d   = cnt_q;
        tick_c  = (state_q == ST_RUN) && (psc_q == PSC_LAST);

        case (state_q)
            ST_STOP: begin
                if (bus.i_clear) begin
                    state_d = ST_CLEAR;
                end else if (bus.i_run_stop) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.i_run_stop) begin
                    state_d = ST_STOP;
                end
                if (tick_c) begin
                    psc_d = '0;
                    if (bus.i_mode) begin
                        cnt_d = (cnt_q == '0) ? CNT_MAX : (cnt_q - CNT_W'(1));
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? '0 : (cnt_q + CNT_W'(1));
                    end
                end else begin
                    psc_d = psc_q + PSC_W'(1);
                end
            end

            ST_CLEAR: begin
                state_d = ST_STOP;
                psc_d   = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    // State, prescaler, count and run flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            psc_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            cnt_q   <= cnt_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

    assign bus.o_cnt_data = cnt_q;
    assign bus.o_run      = run_q;
    assign bus.o_tick     = tick_c;

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run/stop/clear controller that sequences the 0–9999 display counter. It converts single-cycle command pulses into a RUN/STOP/CLEAR state machine and generates the count tick from a prescaler. It owns the 14-bit count register whose value feeds the four-digit FND display controller's `cnt_data` input. The block sits between the button debouncers and the display path.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `TICK_HZ`, default 10: count rate. Prescaler divisor is DIV = CLK_HZ / TICK_HZ, and DIV must be ≥ 2.
- `MAX_COUNT`, default 9999: terminal count. Must fit in 14 bits.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `i_run_stop` input 1: one-cycle pulse from the debouncer; toggles RUN/STOP.
- `i_clear` input 1: one-cycle pulse; zeroes the count (STOP only).
- `i_mode` input 1: count direction, 0 = up, 1 = down. Level; sampled only on tick cycles.
- `o_cnt_data` output 14: current count, 0..MAX_COUNT, registered.
- `o_run` output 1: high while state = RUN, registered-state decode.
- `o_tick` output 1: high for the one cycle in which the count updates (debug/LED).

## Operation
- States: STOP, RUN, CLEAR. Reset state is STOP.
- Transitions:
  - STOP: `i_clear` → CLEAR. Else `i_run_stop` → RUN. Else stay in STOP.
  - RUN: `i_run_stop` → STOP. `i_clear` is ignored in RUN.
  - CLEAR: unconditionally → STOP after one cycle. Pulses arriving during CLEAR are dropped.
- Simultaneous `i_clear` and `i_run_stop` in STOP: clear wins; the run request is dropped.
- Prescaler `psc`, ceil(log2(DIV)) bits:
  - In RUN, increments 0..DIV-1 and wraps to 0.
  - In STOP, holds its value, so a resume finishes the partial interval.
  - Forced to 0 in CLEAR and on `rst`.
- Tick: `o_tick` = (state == RUN) && (psc == DIV-1). Combinational from registered state.
- Count update, on the edge ending a tick cycle:
  - Up: `cnt` = (cnt == MAX_COUNT) ? 0 : cnt+1.
  - Down: `cnt` = (cnt == 0) ? MAX_COUNT : cnt-1.
- Count in CLEAR: `cnt` ← 0 on the edge leaving CLEAR. In the CLEAR cycle itself, `o_cnt_data` still shows the old value.
- Holding behaviour: `cnt` changes only on tick or CLEAR. `i_mode` changes between ticks have no effect until the next tick.
- All arithmetic is unsigned, 14-bit. No value above MAX_COUNT is ever produced.
- Reset values: `o_cnt_data` = 0, `o_run` = 0, `o_tick` = 0, `psc` = 0, state = STOP. Reset overrides every input in the same cycle.

## Timing
- Command latency: a pulse sampled at edge k takes effect at edge k, so `o_run` changes in cycle k+1.
- Clear latency: `i_clear` at edge k puts CLEAR in cycle k+1. `o_cnt_data` = 0 from cycle k+2.
- First tick after RUN from a fresh clear: `o_tick` is high in the DIV-th cycle of RUN, and `o_cnt_data` updates at the end of that cycle.
  - Run entered at edge k with psc = 0 → tick in cycle k+DIV, new count visible in cycle k+DIV+1.
- Steady state: exactly one tick every DIV cycles while in RUN.
- Stop on the tick cycle: if `i_run_stop` arrives in a tick cycle, the count update still happens on that edge and psc wraps to 0.
- Reset mid-count: `rst` high at any edge gives all reset values in the next cycle. A held command pulse is ignored while `rst` = 1.

## Test plan
Benches use CLK_HZ=100, TICK_HZ=10 (DIV=10), MAX_COUNT=9999.
- Reset then run:
  - Stimulus: rst for 2 cycles, then `i_run_stop` pulse, then run 35 cycles.
  - Response: `o_run` = 1 the cycle after the pulse; `o_tick` every 10 cycles; `o_cnt_data` reads 1, 2, 3.
- Pause and resume:
  - Stimulus: stop after psc reaches 6, wait 50 cycles, then run again.
  - Response: count is frozen while stopped; the next tick comes 3 cycles after resume (psc 7, 8, 9).
- Clear rules:
  - Stimulus: `i_clear` during RUN; then stop at count 3 and pulse clear.
  - Response: clear is ignored in RUN. After the stop/clear, count reads 3 during CLEAR and 0 the following cycle; `o_run` stays 0.
- Wrap both ways:
  - Stimulus: preload to 9999 via the up-tick sequence (or force), tick up; then with `i_mode`=1, tick down from 0.
  - Response: up-tick 9999 → 0; down-tick 0 → 9999.
- Simultaneous commands:
  - Stimulus: assert `i_clear` and `i_run_stop` together in STOP with count 5.
  - Response: CLEAR, then STOP; count = 0; `o_run` never goes high.
- Reset mid-run:
  - Stimulus: assert rst at count 7, psc 4.
  - Response: next cycle count = 0, `o_run` = 0, psc = 0. The first tick after a new run arrives 10 cycles after run entry.
